// File: rtl/bcd_addsub_sequencer_pkg.sv
// Shared encodings and constants for the digit-serial BCD add/subtract sequencer.
package bcd_addsub_sequencer_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic [DIGIT_W-1:0] C9 = 4'b1001;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      PASS1 = 3'd2,
      EAC   = 3'd3,
      COMP  = 3'd4,
      DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/bcd_addsub_sequencer_digit_adder.sv
// Single-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_adder
   import bcd_addsub_sequencer_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout
);

   logic [DIGIT_W:0] w_bin;

   always_comb begin
      w_bin = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(cin);
      sum   = w_bin[DIGIT_W-1:0];
      cout  = 1'b0;
      if (w_bin > (DIGIT_W+1)'(9)) begin
         sum  = DIGIT_W'(w_bin + (DIGIT_W+1)'(6));
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_addsub_sequencer.sv
// Digit-serial BCD add/subtract: nine's-complement pass, then end-around carry or
// final complement, sharing one digit adder across passes.
module bcd_addsub_sequencer
   import bcd_addsub_sequencer_pkg::*;
#(
   parameter int unsigned DIGIT_NUM = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           op,
   input  logic [DIGIT_W*DIGIT_NUM-1:0]   A,
   input  logic [DIGIT_W*DIGIT_NUM-1:0]   B,
   output logic                           busy,
   output logic                           done,
   output logic [DIGIT_W*DIGIT_NUM-1:0]   S,
   output logic                           cout,
   output logic                           neg,
   output logic                           err
);

   localparam int unsigned W  = DIGIT_W * DIGIT_NUM;
   localparam int unsigned CW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGIT_NUM - 1);

   state_e          r_state, w_state_nxt;
   logic [W-1:0]    r_a, r_b, r_s, w_a_nxt, w_b_nxt, w_s_nxt;
   logic            r_op, w_op_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_carry, w_carry_nxt;
   logic            r_cout, r_neg, r_err, r_busy, r_done;
   logic            w_cout_nxt, w_neg_nxt, w_err_nxt;

   logic [DIGIT_W-1:0] w_a_dig, w_b_dig, w_s_dig, w_y_dig;
   logic [DIGIT_W-1:0] w_add_a, w_add_b, w_dsum;
   logic               w_dcout, w_bad;
   logic [W-1:0]       w_s_comp;

   assign w_a_dig = r_a[DIGIT_W*r_cnt +: DIGIT_W];
   assign w_b_dig = r_b[DIGIT_W*r_cnt +: DIGIT_W];
   assign w_s_dig = r_s[DIGIT_W*r_cnt +: DIGIT_W];
   assign w_y_dig = (r_op == OP_SUB) ? (C9 - w_b_dig) : w_b_dig;

   // EAC reuses the adder to ripple +1 through S; PASS1 feeds A and Y.
   assign w_add_a = (r_state == EAC) ? w_s_dig : w_a_dig;
   assign w_add_b = (r_state == EAC) ? '0 : w_y_dig;

   bcd_digit_adder u_digit_adder (
      .a    (w_add_a),
      .b    (w_add_b),
      .cin  (r_carry),
      .sum  (w_dsum),
      .cout (w_dcout)
   );

   always_comb begin
      w_bad    = 1'b0;
      w_s_comp = '0;
      for (int i = 0; i < int'(DIGIT_NUM); i++) begin
         if (r_a[DIGIT_W*i +: DIGIT_W] > C9 || r_b[DIGIT_W*i +: DIGIT_W] > C9)
            w_bad = 1'b1;
         w_s_comp[DIGIT_W*i +: DIGIT_W] = C9 - r_s[DIGIT_W*i +: DIGIT_W];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_s_nxt     = r_s;
      w_cnt_nxt   = r_cnt;
      w_carry_nxt = r_carry;
      w_cout_nxt  = r_cout;
      w_neg_nxt   = r_neg;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_a_nxt     = A;
               w_b_nxt     = B;
               w_op_nxt    = op;
               w_s_nxt     = '0;
               w_cout_nxt  = 1'b0;
               w_neg_nxt   = 1'b0;
               w_err_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_carry_nxt = 1'b0;
               w_state_nxt = CHECK;
            end
         end
         CHECK: begin
            w_cnt_nxt   = '0;
            w_carry_nxt = 1'b0;
            if (w_bad) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = PASS1;
            end
         end
         PASS1: begin
            w_s_nxt[DIGIT_W*r_cnt +: DIGIT_W] = w_dsum;
            w_carry_nxt = w_dcout;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               w_cnt_nxt = '0;
               if (r_op == OP_ADD) begin
                  w_cout_nxt  = w_dcout;
                  w_carry_nxt = 1'b0;
                  w_state_nxt = DONE;
               end else if (w_dcout) begin
                  w_carry_nxt = 1'b1;
                  w_state_nxt = EAC;
               end else begin
                  w_carry_nxt = 1'b0;
                  w_state_nxt = COMP;
               end
            end
         end
         EAC: begin
            w_s_nxt[DIGIT_W*r_cnt +: DIGIT_W] = w_dsum;
            w_carry_nxt = w_dcout;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               w_cnt_nxt   = '0;
               w_carry_nxt = 1'b0;
               w_state_nxt = DONE;
            end
         end
         COMP: begin
            // A == B lands here with S all nines; its complement is zero, not negative.
            w_s_nxt     = w_s_comp;
            w_neg_nxt   = (w_s_comp != '0);
            w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 1'b0;
         r_s     <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_neg   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_s     <= w_s_nxt;
         r_cnt   <= w_cnt_nxt;
         r_carry <= w_carry_nxt;
         r_cout  <= w_cout_nxt;
         r_neg   <= w_neg_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (w_state_nxt == DONE);
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign S    = r_s;
   assign cout = r_cout;
   assign neg  = r_neg;
   assign err  = r_err;

endmodule
